// File: rtl/uart_rx_ctrl.sv
// Host-side controller for the configurable UART receive path: frame-boundary
// config staging, frame activity/timeout tracking, error status and FIFO reads.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | line idle; staged config may be applied while rx_s is high
// ST_FRAME| frame in progress; baud ticks counted against the timeout
module uart_rx_ctrl #(
  parameter int DVSR_BIT      = 11,
  parameter int DVSR_RST      = 650,
  parameter int TIMEOUT_TICKS = 208
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_rx,
  input  logic                i_baud_tick,
  input  logic                i_rx_done_tick,
  input  logic                i_par_err,
  input  logic                i_frm_err,
  input  logic                i_fifo_empty,
  input  logic                i_fifo_full,
  input  logic [7:0]          i_fifo_rd_data,
  input  logic                i_cfg_wr,
  input  logic [1:0]          i_cfg_data_num,
  input  logic [1:0]          i_cfg_stop_num,
  input  logic [1:0]          i_cfg_par,
  input  logic [DVSR_BIT-1:0] i_cfg_dvsr,
  input  logic                i_clr_status,
  input  logic                i_rd_req,
  output logic [1:0]          o_data_num,
  output logic [1:0]          o_stop_num,
  output logic [1:0]          o_par,
  output logic [DVSR_BIT-1:0] o_dvsr,
  output logic                o_cfg_pending,
  output logic                o_cfg_applied,
  output logic                o_busy,
  output logic                o_timeout,
  output logic                o_fifo_rd,
  output logic [7:0]          o_rd_data,
  output logic                o_rd_valid,
  output logic                o_rd_underflow,
  output logic                o_par_err_st,
  output logic                o_frm_err_st,
  output logic                o_over_err_st,
  output logic [7:0]          o_err_count
);

  typedef enum logic {ST_IDLE, ST_FRAME} state_t;

  localparam logic [DVSR_BIT-1:0] DVSR_RST_V = DVSR_BIT'(DVSR_RST);
  localparam logic [7:0]          TICK_LAST  = 8'(TIMEOUT_TICKS - 1);

  state_t              state;
  logic [7:0]          tick_cnt;
  logic                rx_meta, rx_s;
  logic [1:0]          stg_data_num, stg_stop_num, stg_par;
  logic [DVSR_BIT-1:0] stg_dvsr;
  logic                apply_ok;
  logic                par_hit, any_err;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      o_busy    <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state    <= ST_FRAME;
            tick_cnt <= '0;
            o_busy   <= 1'b1;
          end
        end
        ST_FRAME: begin
          if (i_baud_tick) tick_cnt <= tick_cnt + 8'd1;
          // A done tick coinciding with the last allowed tick ends the frame normally.
          if (i_rx_done_tick) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else if (i_baud_tick && tick_cnt == TICK_LAST) begin
            state     <= ST_IDLE;
            o_busy    <= 1'b0;
            o_timeout <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  assign apply_ok = (state == ST_IDLE) && rx_s && o_cfg_pending && !i_cfg_wr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stg_data_num  <= 2'b10;
      stg_stop_num  <= 2'b00;
      stg_par       <= 2'b00;
      stg_dvsr      <= DVSR_RST_V;
      o_data_num    <= 2'b10;
      o_stop_num    <= 2'b00;
      o_par         <= 2'b00;
      o_dvsr        <= DVSR_RST_V;
      o_cfg_pending <= 1'b0;
      o_cfg_applied <= 1'b0;
    end else begin
      o_cfg_applied <= 1'b0;
      if (i_cfg_wr) begin
        stg_data_num  <= i_cfg_data_num;
        stg_stop_num  <= i_cfg_stop_num;
        stg_par       <= i_cfg_par;
        stg_dvsr      <= i_cfg_dvsr;
        o_cfg_pending <= 1'b1;
      end else if (apply_ok) begin
        o_data_num    <= stg_data_num;
        o_stop_num    <= stg_stop_num;
        o_par         <= stg_par;
        o_dvsr        <= stg_dvsr;
        o_cfg_pending <= 1'b0;
        o_cfg_applied <= 1'b1;
      end
    end
  end

  // Parity settings 00 and 11 both mean no parity bit, so the receiver flag is ignored.
  assign par_hit = i_par_err && (o_par == 2'b01 || o_par == 2'b10);
  assign any_err = par_hit || i_frm_err || i_fifo_full;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_par_err_st  <= 1'b0;
      o_frm_err_st  <= 1'b0;
      o_over_err_st <= 1'b0;
      o_err_count   <= '0;
    end else if (i_clr_status) begin
      o_par_err_st  <= i_rx_done_tick && par_hit;
      o_frm_err_st  <= i_rx_done_tick && i_frm_err;
      o_over_err_st <= i_rx_done_tick && i_fifo_full;
      o_err_count   <= (i_rx_done_tick && any_err) ? 8'd1 : 8'd0;
    end else if (i_rx_done_tick) begin
      if (par_hit)     o_par_err_st  <= 1'b1;
      if (i_frm_err)   o_frm_err_st  <= 1'b1;
      if (i_fifo_full) o_over_err_st <= 1'b1;
      if (any_err && o_err_count != 8'hFF) o_err_count <= o_err_count + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_rd_data      <= '0;
      o_rd_valid     <= 1'b0;
      o_fifo_rd      <= 1'b0;
      o_rd_underflow <= 1'b0;
    end else begin
      o_rd_valid     <= 1'b0;
      o_fifo_rd      <= 1'b0;
      o_rd_underflow <= 1'b0;
      // During the pop cycle the FIFO flags still describe the old head.
      if (i_rd_req && !o_fifo_rd) begin
        if (!i_fifo_empty) begin
          o_rd_data  <= i_fifo_rd_data;
          o_rd_valid <= 1'b1;
          o_fifo_rd  <= 1'b1;
        end else begin
          o_rd_underflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: config staging, frame tracking/timeout,
// error status and read sequencing with hand-computed expectations.
module tb_uart_rx_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset, i_rx, i_baud_tick, i_rx_done_tick, i_par_err, i_frm_err;
  logic        i_fifo_empty, i_fifo_full, i_cfg_wr, i_clr_status, i_rd_req;
  logic [7:0]  i_fifo_rd_data;
  logic [1:0]  i_cfg_data_num, i_cfg_stop_num, i_cfg_par;
  logic [10:0] i_cfg_dvsr;
  logic [1:0]  o_data_num, o_stop_num, o_par;
  logic [10:0] o_dvsr;
  logic        o_cfg_pending, o_cfg_applied, o_busy, o_timeout, o_fifo_rd;
  logic [7:0]  o_rd_data, o_err_count;
  logic        o_rd_valid, o_rd_underflow, o_par_err_st, o_frm_err_st, o_over_err_st;

  int checks = 0;
  int failures = 0;

  uart_rx_ctrl #(.DVSR_BIT(11), .DVSR_RST(650), .TIMEOUT_TICKS(208)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx(i_rx), .i_baud_tick(i_baud_tick),
    .i_rx_done_tick(i_rx_done_tick), .i_par_err(i_par_err), .i_frm_err(i_frm_err),
    .i_fifo_empty(i_fifo_empty), .i_fifo_full(i_fifo_full), .i_fifo_rd_data(i_fifo_rd_data),
    .i_cfg_wr(i_cfg_wr), .i_cfg_data_num(i_cfg_data_num), .i_cfg_stop_num(i_cfg_stop_num),
    .i_cfg_par(i_cfg_par), .i_cfg_dvsr(i_cfg_dvsr), .i_clr_status(i_clr_status),
    .i_rd_req(i_rd_req), .o_data_num(o_data_num), .o_stop_num(o_stop_num), .o_par(o_par),
    .o_dvsr(o_dvsr), .o_cfg_pending(o_cfg_pending), .o_cfg_applied(o_cfg_applied),
    .o_busy(o_busy), .o_timeout(o_timeout), .o_fifo_rd(o_fifo_rd), .o_rd_data(o_rd_data),
    .o_rd_valid(o_rd_valid), .o_rd_underflow(o_rd_underflow), .o_par_err_st(o_par_err_st),
    .o_frm_err_st(o_frm_err_st), .o_over_err_st(o_over_err_st), .o_err_count(o_err_count)
  );

  always #5 i_clk = ~i_clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] dn, input logic [1:0] sn,
                           input logic [1:0] pr, input logic [10:0] dv);
    i_cfg_wr = 1'b1; i_cfg_data_num = dn; i_cfg_stop_num = sn; i_cfg_par = pr; i_cfg_dvsr = dv;
    step();
    i_cfg_wr = 1'b0;
  endtask

  task automatic frame_done(input logic pe, input logic fe, input logic full, input logic clr);
    i_rx_done_tick = 1'b1; i_par_err = pe; i_frm_err = fe; i_fifo_full = full; i_clr_status = clr;
    step();
    i_rx_done_tick = 1'b0; i_par_err = 1'b0; i_frm_err = 1'b0; i_fifo_full = 1'b0; i_clr_status = 1'b0;
  endtask

  task automatic clear_status();
    i_clr_status = 1'b1;
    step();
    i_clr_status = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1; i_rx = 1'b1; i_baud_tick = 1'b0; i_rx_done_tick = 1'b0;
    i_par_err = 1'b0; i_frm_err = 1'b0; i_fifo_empty = 1'b1; i_fifo_full = 1'b0;
    i_fifo_rd_data = 8'h00; i_cfg_wr = 1'b0; i_cfg_data_num = 2'b00; i_cfg_stop_num = 2'b00;
    i_cfg_par = 2'b00; i_cfg_dvsr = 11'd0; i_clr_status = 1'b0; i_rd_req = 1'b0;
    repeat (3) step();
    i_reset = 1'b0;
    step();

    // reset state
    chk("rst_data_num", o_data_num, 2'b10);
    chk("rst_stop_num", o_stop_num, 2'b00);
    chk("rst_par", o_par, 2'b00);
    chk("rst_dvsr", o_dvsr, 11'd650);
    chk("rst_pending", o_cfg_pending, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_err_count", o_err_count, 8'd0);
    chk("rst_rd_data", o_rd_data, 8'd0);
    chk("rst_sticky", {o_par_err_st, o_frm_err_st, o_over_err_st}, 3'b000);

    // idle-line config write: pending one cycle, then applied
    cfg_write(2'b01, 2'b00, 2'b01, 11'd10);
    chk("idle_pending", o_cfg_pending, 1'b1);
    chk("idle_applied_early", o_cfg_applied, 1'b0);
    chk("idle_data_num_old", o_data_num, 2'b10);
    step();
    chk("idle_applied", o_cfg_applied, 1'b1);
    chk("idle_pending_clr", o_cfg_pending, 1'b0);
    chk("idle_cfg_out", {o_data_num, o_stop_num, o_par}, {2'b01, 2'b00, 2'b01});
    chk("idle_dvsr", o_dvsr, 11'd10);
    step();
    chk("idle_applied_pulse", o_cfg_applied, 1'b0);

    // start bit: busy after 3 edges
    i_rx = 1'b0;
    step(); step();
    chk("busy_lat2", o_busy, 1'b0);
    step();
    chk("busy_lat3", o_busy, 1'b1);

    // config write mid-frame is held until the frame ends
    cfg_write(2'b11, 2'b01, 2'b00, 11'd100);
    chk("mid_pending", o_cfg_pending, 1'b1);
    i_rx = 1'b1;
    repeat (4) step();
    chk("mid_hold_data_num", o_data_num, 2'b01);
    chk("mid_hold_applied", o_cfg_applied, 1'b0);
    chk("mid_busy", o_busy, 1'b1);
    i_rx_done_tick = 1'b1;
    step();
    i_rx_done_tick = 1'b0;
    chk("mid_done_busy", o_busy, 1'b0);
    chk("mid_done_hold", o_data_num, 2'b01);
    chk("mid_done_applied", o_cfg_applied, 1'b0);
    step();
    chk("mid_applied", o_cfg_applied, 1'b1);
    chk("mid_cfg_out", {o_data_num, o_stop_num, o_par}, {2'b11, 2'b01, 2'b00});
    chk("mid_dvsr", o_dvsr, 11'd100);

    // 5 frames into a depth-4 FIFO: overrun on the fifth
    for (int i = 0; i < 5; i++) begin
      frame_done(1'b0, 1'b0, (i == 4), 1'b0);
      step();
    end
    chk("ovr_flag", o_over_err_st, 1'b1);
    chk("ovr_count", o_err_count, 8'd1);
    chk("ovr_others", {o_par_err_st, o_frm_err_st}, 2'b00);
    clear_status();
    chk("ovr_clr_flag", o_over_err_st, 1'b0);
    chk("ovr_clr_count", o_err_count, 8'd0);

    // parity error honoured only with parity enabled
    cfg_write(2'b11, 2'b00, 2'b01, 11'd100);
    step();
    chk("par_cfg", o_par, 2'b01);
    frame_done(1'b1, 1'b0, 1'b0, 1'b0);
    chk("par_even_flag", o_par_err_st, 1'b1);
    chk("par_even_count", o_err_count, 8'd1);
    clear_status();
    cfg_write(2'b11, 2'b00, 2'b00, 11'd100);
    step();
    frame_done(1'b1, 1'b0, 1'b0, 1'b0);
    chk("par_none_flag", o_par_err_st, 1'b0);
    chk("par_none_count", o_err_count, 8'd0);
    cfg_write(2'b11, 2'b00, 2'b11, 11'd100);
    step();
    frame_done(1'b1, 1'b0, 1'b0, 1'b0);
    chk("par_11_flag", o_par_err_st, 1'b0);

    // clear coincident with a capture: clear first, then set
    frame_done(1'b0, 1'b1, 1'b0, 1'b0);
    frame_done(1'b0, 1'b1, 1'b0, 1'b0);
    chk("clrcap_pre_count", o_err_count, 8'd2);
    frame_done(1'b0, 1'b1, 1'b0, 1'b1);
    chk("clrcap_count", o_err_count, 8'd1);
    chk("clrcap_frm", o_frm_err_st, 1'b1);

    // count saturation
    clear_status();
    i_rx_done_tick = 1'b1; i_frm_err = 1'b1;
    repeat (254) step();
    chk("sat_254", o_err_count, 8'd254);
    step();
    chk("sat_255", o_err_count, 8'd255);
    repeat (5) step();
    chk("sat_hold", o_err_count, 8'd255);
    i_rx_done_tick = 1'b0; i_frm_err = 1'b0;
    clear_status();

    // timeout after 208 ticks with no done tick
    i_rx = 1'b0;
    repeat (3) step();
    chk("to_busy", o_busy, 1'b1);
    i_baud_tick = 1'b1;
    repeat (200) step();
    i_rx = 1'b1;
    repeat (7) step();
    chk("to_207_pulse", o_timeout, 1'b0);
    chk("to_207_busy", o_busy, 1'b1);
    step();
    i_baud_tick = 1'b0;
    chk("to_208_pulse", o_timeout, 1'b1);
    chk("to_208_busy", o_busy, 1'b0);
    step();
    chk("to_pulse_end", o_timeout, 1'b0);
    chk("to_idle", o_busy, 1'b0);

    // done tick coinciding with the final tick wins
    i_rx = 1'b0;
    repeat (3) step();
    i_rx = 1'b1;
    i_baud_tick = 1'b1;
    repeat (207) step();
    chk("tie_busy", o_busy, 1'b1);
    i_rx_done_tick = 1'b1;
    step();
    i_baud_tick = 1'b0; i_rx_done_tick = 1'b0;
    chk("tie_no_timeout", o_timeout, 1'b0);
    chk("tie_busy_low", o_busy, 1'b0);
    step();
    chk("tie_no_timeout2", o_timeout, 1'b0);

    // reads: 0x3D, request during pop ignored, 0x1E, then underflow
    i_fifo_empty = 1'b0; i_fifo_rd_data = 8'h3D; i_rd_req = 1'b1;
    step();
    chk("rd1_valid", o_rd_valid, 1'b1);
    chk("rd1_pop", o_fifo_rd, 1'b1);
    chk("rd1_data", o_rd_data, 8'h3D);
    i_fifo_rd_data = 8'h1E;
    step();
    chk("rd_ignored_valid", o_rd_valid, 1'b0);
    chk("rd_ignored_pop", o_fifo_rd, 1'b0);
    chk("rd_ignored_data", o_rd_data, 8'h3D);
    step();
    i_rd_req = 1'b0;
    chk("rd2_valid", o_rd_valid, 1'b1);
    chk("rd2_data", o_rd_data, 8'h1E);
    step();
    i_fifo_empty = 1'b1; i_rd_req = 1'b1;
    step();
    i_rd_req = 1'b0;
    chk("rd_uflow", o_rd_underflow, 1'b1);
    chk("rd_uflow_valid", o_rd_valid, 1'b0);
    chk("rd_uflow_pop", o_fifo_rd, 1'b0);
    step();
    chk("rd_uflow_pulse", o_rd_underflow, 1'b0);

    // reset mid-frame with pending config
    i_rx = 1'b0;
    repeat (3) step();
    cfg_write(2'b00, 2'b10, 2'b10, 11'd33);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0; i_rx = 1'b1;
    chk("rst2_busy", o_busy, 1'b0);
    chk("rst2_pending", o_cfg_pending, 1'b0);
    chk("rst2_cfg", {o_data_num, o_stop_num, o_par}, {2'b10, 2'b00, 2'b00});
    chk("rst2_dvsr", o_dvsr, 11'd650);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
